// File: rtl/txseq_pkg.sv
// txseq_pkg: shared definitions for the Transfer Register strobe sequencer.
// Holds the op encoding, the FSM state encoding, the bit position of each
// strobe inside the packed strobe vector, and the op-to-strobe decode.
// Optional feature macro used by the sequencer: TXSEQ_TURNAROUND_EN.
package txseq_pkg;

  // Ops a pipeline stage can request.
  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_LD_HI    = 3'd1;
  localparam logic [2:0] OP_LD_LO    = 3'd2;
  localparam logic [2:0] OP_LD_XFER  = 3'd3;
  localparam logic [2:0] OP_DRV_ADDR = 3'd4;
  localparam logic [2:0] OP_DRV_XFER = 3'd5;
  localparam logic [2:0] OP_DRV_HI   = 3'd6;
  localparam logic [2:0] OP_DRV_LO   = 3'd7;

  // Sequencer FSM states. ST_TURN is only reachable with turnaround enabled.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_TURN   = 2'd2
  } state_e;

  // Bit position of each active-low strobe in the packed strobe vector.
  localparam int STROBE_IDX_L_TH      = 0;
  localparam int STROBE_IDX_L_TL      = 1;
  localparam int STROBE_IDX_L_TX      = 2;
  localparam int STROBE_IDX_A_TX_ADDR = 3;
  localparam int STROBE_IDX_A_TX_XFER = 4;
  localparam int STROBE_IDX_A_TH      = 5;
  localparam int STROBE_IDX_A_TL      = 6;

  // All seven strobes released (high).
  localparam logic [6:0] STROBES_OFF = 7'h7F;

  // Active-low strobe pattern for an op: exactly one bit low, none for NOP.
  function automatic logic [6:0] strobe_mask(input logic [2:0] op);
    logic [6:0] m;
    m = STROBES_OFF;
    case (op)
      OP_LD_HI:    m[STROBE_IDX_L_TH]      = 1'b0;
      OP_LD_LO:    m[STROBE_IDX_L_TL]      = 1'b0;
      OP_LD_XFER:  m[STROBE_IDX_L_TX]      = 1'b0;
      OP_DRV_ADDR: m[STROBE_IDX_A_TX_ADDR] = 1'b0;
      OP_DRV_XFER: m[STROBE_IDX_A_TX_XFER] = 1'b0;
      OP_DRV_HI:   m[STROBE_IDX_A_TH]      = 1'b0;
      OP_DRV_LO:   m[STROBE_IDX_A_TL]      = 1'b0;
      default:     m = STROBES_OFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/txseq_rr_arbiter.sv
// txseq_rr_arbiter: purely combinational round-robin picker.
// Searches valid[] starting at ptr and wrapping modulo NREQ; returns the
// first hit as a one-hot grant plus its index. The pointer lives in the parent.
module txseq_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      grant_idx,
  output logic            grant_vld
);

  logic [7:0] valid_pad_s;
  logic [3:0] cand_s;
  logic       found_s;

  // Zero-extend so a 3-bit candidate index can always select a bit.
  assign valid_pad_s = 8'(valid);

  // Walk the candidates from ptr upward, wrapping, and keep the first valid one.
  always_comb begin
    grant_idx = 3'd0;
    found_s   = 1'b0;
    cand_s    = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, ptr} + 4'(k);
      if (cand_s >= 4'(NREQ)) begin
        cand_s = cand_s - 4'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && valid_pad_s[cand_s[2:0]]) begin
        found_s   = 1'b1;
        grant_idx = cand_s[2:0];
      end else begin
        found_s   = found_s;
      end
    end
  end

  // Expand the winning index into a one-hot grant vector.
  always_comb begin
    grant = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (found_s && (grant_idx == 3'(i))) begin
        grant[i] = 1'b1;
      end else begin
        grant[i] = 1'b0;
      end
    end
  end

  assign grant_vld = found_s;

endmodule

// File: rtl/transfer_reg_sequencer.sv
// transfer_reg_sequencer: arbitrates pipeline-stage requests for the seven
// active-low Transfer Register strobes and sequences them so that exactly one
// strobe (or none) is low in any cycle. Requests are accepted only in IDLE,
// winners chosen round-robin; the chosen strobe is held low for STROBE_CYCLES
// clocks straight from a flop, then done/done_id pulse for one cycle.
// Optional feature macro: TXSEQ_TURNAROUND_EN -- when defined, every DRV_* op
// is followed by one TURN cycle with all strobes high before returning to IDLE.
module transfer_reg_sequencer
  import txseq_pkg::*;
#(
  parameter int NREQ          = 2,
  parameter int STROBE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_op,
  output logic [NREQ-1:0]   req_ready,
  output logic              done,
  output logic [2:0]        done_id,
  output logic              busy,
  output logic              l_th_n,
  output logic              l_tl_n,
  output logic              l_tx_n,
  output logic              a_tx_addr_n,
  output logic              a_tx_xfer_n,
  output logic              a_th_n,
  output logic              a_tl_n
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  id_q, id_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [6:0]  strobe_q, strobe_d;
  logic        done_q, done_d;
  logic [2:0]  done_id_q, done_id_d;
  logic        busy_q, busy_d;

  logic [NREQ-1:0] grant_s;
  logic [2:0]      grant_idx_s;
  logic            grant_vld_s;
  logic [2:0]      op_sel_s;
  logic            accept_s;

  txseq_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .valid     (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_vld (grant_vld_s)
  );

  // An accept happens only in IDLE, only with a winner, and never while in reset.
  assign accept_s  = (state_q == ST_IDLE) && grant_vld_s && rst_n;
  assign req_ready = accept_s ? grant_s : {NREQ{1'b0}};

  // Pick the op of the granted requester out of the packed op bus.
  always_comb begin
    op_sel_s = OP_NOP;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        op_sel_s = req_op[3*i +: 3];
      end else begin
        op_sel_s = op_sel_s;
      end
    end
  end

  // Next-state, counter, latched command and registered strobe/done decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    id_d      = id_q;
    rr_ptr_d  = rr_ptr_q;
    strobe_d  = STROBES_OFF;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d = op_sel_s;
          id_d = grant_idx_s;
          if (grant_idx_s == 3'(NREQ-1)) begin
            rr_ptr_d = 3'd0;
          end else begin
            rr_ptr_d = grant_idx_s + 3'd1;
          end
          if (op_sel_s == OP_NOP) begin
            // Nothing to strobe: complete on the very next cycle.
            done_d    = 1'b1;
            done_id_d = grant_idx_s;
            state_d   = ST_IDLE;
          end else begin
            state_d  = ST_STROBE;
            cnt_d    = 4'(STROBE_CYCLES - 1);
            strobe_d = strobe_mask(op_sel_s);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          // Last low cycle: release the strobe, done shows next cycle.
          done_d    = 1'b1;
          done_id_d = id_q;
`ifdef TXSEQ_TURNAROUND_EN
          if (op_q[2]) begin
            state_d = ST_TURN;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d    = cnt_q - 4'd1;
          strobe_d = strobe_mask(op_q);
        end
      end
      ST_TURN: begin
        // Bus turnaround: one dead cycle with every strobe high.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset releases every strobe without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      op_q      <= OP_NOP;
      id_q      <= 3'd0;
      rr_ptr_q  <= 3'd0;
      strobe_q  <= STROBES_OFF;
      done_q    <= 1'b0;
      done_id_q <= 3'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      id_q      <= id_d;
      rr_ptr_q  <= rr_ptr_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      busy_q    <= busy_d;
    end
  end

  assign done        = done_q;
  assign done_id     = done_id_q;
  assign busy        = busy_q;
  assign l_th_n      = strobe_q[STROBE_IDX_L_TH];
  assign l_tl_n      = strobe_q[STROBE_IDX_L_TL];
  assign l_tx_n      = strobe_q[STROBE_IDX_L_TX];
  assign a_tx_addr_n = strobe_q[STROBE_IDX_A_TX_ADDR];
  assign a_tx_xfer_n = strobe_q[STROBE_IDX_A_TX_XFER];
  assign a_th_n      = strobe_q[STROBE_IDX_A_TH];
  assign a_tl_n      = strobe_q[STROBE_IDX_A_TL];

endmodule

// File: tb/tb_transfer_reg_sequencer.sv
// Testbench for transfer_reg_sequencer. Instance A: NREQ=2, STROBE_CYCLES=1.
// Instance B: NREQ=3, STROBE_CYCLES=3. A small Transfer Register / bus model
// sits around the strobes. Honors TXSEQ_TURNAROUND_EN for expected timing.
module tb_transfer_reg_sequencer;

`ifdef TXSEQ_TURNAROUND_EN
  localparam int TURN_CYC = 1;
`else
  localparam int TURN_CYC = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instance A
  logic [1:0] valid_a = 2'b00;
  logic [5:0] op_a = 6'd0;
  logic [1:0] ready_a;
  logic done_a, busy_a;
  logic [2:0] done_id_a;
  logic l_th_n_a, l_tl_n_a, l_tx_n_a, a_tx_addr_n_a, a_tx_xfer_n_a, a_th_n_a, a_tl_n_a;
  logic [6:0] str_a;

  // Instance B
  logic [2:0] valid_b = 3'b000;
  logic [8:0] op_b = 9'd0;
  logic [2:0] ready_b;
  logic done_b, busy_b;
  logic [2:0] done_id_b;
  logic l_th_n_b, l_tl_n_b, l_tx_n_b, a_tx_addr_n_b, a_tx_xfer_n_b, a_th_n_b, a_tl_n_b;
  logic [6:0] str_b;

  transfer_reg_sequencer #(.NREQ(2), .STROBE_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_op(op_a), .req_ready(ready_a),
    .done(done_a), .done_id(done_id_a), .busy(busy_a),
    .l_th_n(l_th_n_a), .l_tl_n(l_tl_n_a), .l_tx_n(l_tx_n_a),
    .a_tx_addr_n(a_tx_addr_n_a), .a_tx_xfer_n(a_tx_xfer_n_a), .a_th_n(a_th_n_a), .a_tl_n(a_tl_n_a)
  );

  transfer_reg_sequencer #(.NREQ(3), .STROBE_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_op(op_b), .req_ready(ready_b),
    .done(done_b), .done_id(done_id_b), .busy(busy_b),
    .l_th_n(l_th_n_b), .l_tl_n(l_tl_n_b), .l_tx_n(l_tx_n_b),
    .a_tx_addr_n(a_tx_addr_n_b), .a_tx_xfer_n(a_tx_xfer_n_b), .a_th_n(a_th_n_b), .a_tl_n(a_tl_n_b)
  );

  // Bit k of the packed strobe view belongs to op k+1.
  assign str_a = {a_tl_n_a, a_th_n_a, a_tx_xfer_n_a, a_tx_addr_n_a, l_tx_n_a, l_tl_n_a, l_th_n_a};
  assign str_b = {a_tl_n_b, a_th_n_b, a_tx_xfer_n_b, a_tx_addr_n_b, l_tx_n_b, l_tl_n_b, l_th_n_b};

  // Environment: MainBus feeds the high byte of A; Bus feeds/reads the transfer reg of B.
  logic [7:0]  main_bus = 8'h00;
  logic [7:0]  tr_hi_a = 8'h00;
  logic        drive_en = 1'b0;
  logic [15:0] drive_val = 16'h0000;
  logic [15:0] tx_reg_b = 16'h0000;
  logic [15:0] bus_b;

  assign bus_b = (!a_tx_xfer_n_b) ? tx_reg_b : (drive_en ? drive_val : 16'h0000);

  // Transfer Register latches while its load strobe is low.
  always @(posedge clk) begin
    if (!l_th_n_a) tr_hi_a <= main_bus;
    if (!l_tx_n_b) tx_reg_b <= bus_b;
  end

  // One-strobe invariant, checked on every falling edge for both instances.
  always @(negedge clk) begin
    checks++;
    if ($countones(~str_a) > 1 || $countones(~str_b) > 1) begin
      failures++;
      $display("FAIL one_strobe str_a=%b str_b=%b required at most one low bit", str_a, str_b);
    end
  end

  // Expected active-low pattern for an op, derived from the op table.
  function automatic logic [6:0] exp_mask(input logic [2:0] op);
    logic [6:0] m;
    m = 7'h7F;
    if (op != 3'd0) m[op - 3'd1] = 1'b0;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid_a = 2'b11;
    op_a = 6'b001_001;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (str_a !== 7'h7F) begin failures++; $display("FAIL reset_str_a got=%h want=7f", str_a); end
    checks++; if (str_b !== 7'h7F) begin failures++; $display("FAIL reset_str_b got=%h want=7f", str_b); end
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b want=00", busy_a, busy_b); end
    checks++; if (done_a !== 1'b0 || done_b !== 1'b0) begin failures++; $display("FAIL reset_done got=%b%b want=00", done_a, done_b); end
    checks++; if (done_id_a !== 3'd0) begin failures++; $display("FAIL reset_done_id got=%0d want=0", done_id_a); end
    checks++; if (ready_a !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b want=00", ready_a); end
    valid_a = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || str_a !== 7'h7F) begin
      failures++; $display("FAIL idle_after_reset busy=%b done=%b str=%h want 0 0 7f", busy_a, done_a, str_a); end
  endtask

  task automatic test_ld_hi();
    main_bus = 8'h55;
    valid_a = 2'b01;
    op_a = {3'd0, 3'd1};
    #1;
    checks++; if (ready_a !== 2'b01) begin failures++; $display("FAIL ldhi_ready got=%b want=01", ready_a); end
    step();
    valid_a = 2'b00;
    #1;
    checks++; if (str_a !== 7'h7E) begin failures++; $display("FAIL ldhi_strobe_n1 got=%h want=7e", str_a); end
    checks++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin failures++; $display("FAIL ldhi_busy_n1 busy=%b done=%b want 1 0", busy_a, done_a); end
    step();
    checks++; if (str_a !== 7'h7F) begin failures++; $display("FAIL ldhi_strobe_n2 got=%h want=7f", str_a); end
    checks++; if (done_a !== 1'b1 || done_id_a !== 3'd0) begin failures++; $display("FAIL ldhi_done done=%b id=%0d want 1 0", done_a, done_id_a); end
    checks++; if (tr_hi_a !== 8'h55) begin failures++; $display("FAIL ldhi_tr_hi got=%h want=55", tr_hi_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL ldhi_busy_n2 got=%b want=0", busy_a); end
    step();
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL ldhi_done_n3 got=%b want=0", done_a); end
    main_bus = 8'h00;
  endtask

  task automatic test_nop();
    // Pointer sits at 1 after the previous grant to requester 0.
    valid_a = 2'b11;
    op_a = {3'd0, 3'd2};
    #1;
    checks++; if (ready_a !== 2'b10) begin failures++; $display("FAIL nop_rr_ready got=%b want=10", ready_a); end
    step();
    valid_a = 2'b00;
    #1;
    checks++; if (done_a !== 1'b1 || done_id_a !== 3'd1) begin failures++; $display("FAIL nop_done done=%b id=%0d want 1 1", done_a, done_id_a); end
    checks++; if (busy_a !== 1'b0 || str_a !== 7'h7F) begin failures++; $display("FAIL nop_idle busy=%b str=%h want 0 7f", busy_a, str_a); end
    step();
  endtask

  task automatic test_round_robin();
    valid_a = 2'b11;
    op_a = {3'd5, 3'd4};
    #1;
    checks++; if (ready_a !== 2'b01) begin failures++; $display("FAIL rr_first_ready got=%b want=01", ready_a); end
    step();
    valid_a = 2'b10;
    #1;
    checks++; if (str_a !== 7'h77) begin failures++; $display("FAIL rr_addr_strobe got=%h want=77", str_a); end
    checks++; if (ready_a !== 2'b00) begin failures++; $display("FAIL rr_ready_while_busy got=%b want=00", ready_a); end
    step();
    checks++; if (done_a !== 1'b1 || done_id_a !== 3'd0 || str_a !== 7'h7F) begin
      failures++; $display("FAIL rr_done0 done=%b id=%0d str=%h want 1 0 7f", done_a, done_id_a, str_a); end
    repeat (TURN_CYC) step();
    checks++; if (ready_a !== 2'b10) begin failures++; $display("FAIL rr_second_ready got=%b want=10", ready_a); end
    step();
    valid_a = 2'b00;
    #1;
    checks++; if (str_a !== 7'h6F) begin failures++; $display("FAIL rr_xfer_strobe got=%h want=6f", str_a); end
    step();
    checks++; if (done_a !== 1'b1 || done_id_a !== 3'd1) begin failures++; $display("FAIL rr_done1 done=%b id=%0d want 1 1", done_a, done_id_a); end
    repeat (TURN_CYC) step();
    valid_a = 2'b11;
    op_a = 6'd0;
    #1;
    checks++; if (ready_a !== 2'b01) begin failures++; $display("FAIL rr_ptr_wrapped got=%b want=01", ready_a); end
    step();
    valid_a = 2'b00;
    step();
  endtask

  task automatic test_long_strobe();
    drive_en = 1'b1;
    drive_val = 16'h1234;
    valid_b = 3'b001;
    op_b = {3'd0, 3'd0, 3'd3};
    #1;
    checks++; if (ready_b !== 3'b001) begin failures++; $display("FAIL long_ready got=%b want=001", ready_b); end
    for (int c = 0; c < 3; c++) begin
      step();
      valid_b = 3'b000;
      #1;
      checks++; if (str_b !== 7'h7B) begin failures++; $display("FAIL long_ldx_cycle%0d got=%h want=7b", c, str_b); end
    end
    step();
    checks++; if (str_b !== 7'h7F || done_b !== 1'b1 || done_id_b !== 3'd0) begin
      failures++; $display("FAIL long_ldx_end str=%h done=%b id=%0d want 7f 1 0", str_b, done_b, done_id_b); end
    checks++; if (tx_reg_b !== 16'h1234) begin failures++; $display("FAIL long_tx_reg got=%h want=1234", tx_reg_b); end
    drive_en = 1'b0;
    valid_b = 3'b010;
    op_b = {3'd0, 3'd5, 3'd0};
    #1;
    checks++; if (ready_b !== 3'b010) begin failures++; $display("FAIL long_b2b_ready got=%b want=010", ready_b); end
    for (int c = 0; c < 3; c++) begin
      step();
      valid_b = 3'b000;
      #1;
      checks++; if (a_tx_xfer_n_b !== 1'b0 || bus_b !== 16'h1234) begin
        failures++; $display("FAIL long_drv_cycle%0d strobe=%b bus=%h want 0 1234", c, a_tx_xfer_n_b, bus_b); end
    end
    step();
    checks++; if (done_b !== 1'b1 || done_id_b !== 3'd1 || str_b !== 7'h7F) begin
      failures++; $display("FAIL long_drv_done done=%b id=%0d str=%h want 1 1 7f", done_b, done_id_b, str_b); end
    repeat (TURN_CYC) step();
  endtask

  task automatic test_reset_mid();
    // Pointer now at 2; requester 2 gets LD_HI on instance B.
    valid_b = 3'b100;
    op_b = {3'd1, 3'd0, 3'd0};
    #1;
    checks++; if (ready_b !== 3'b100) begin failures++; $display("FAIL rst_mid_ready got=%b want=100", ready_b); end
    step();
    valid_b = 3'b000;
    step();
    checks++; if (l_th_n_b !== 1'b0) begin failures++; $display("FAIL rst_mid_low_before got=%b want=0", l_th_n_b); end
    rst_n = 1'b0;
    #1;
    checks++; if (l_th_n_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) begin
      failures++; $display("FAIL rst_mid_release strobe=%b busy=%b done=%b want 1 0 0", l_th_n_b, busy_b, done_b); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (done_b !== 1'b0 || str_b !== 7'h7F) begin
        failures++; $display("FAIL rst_mid_after%0d done=%b str=%h want 0 7f", c, done_b, str_b); end
    end
  endtask

  task automatic test_random();
    logic [2:0] valid_r;
    logic [2:0] ops [3];
    logic [2:0] granted_prev;
    logic [2:0] last_op;
    logic [2:0] want;
    logic [2:0] exp_q [$];
    int waits [3];
    int accepts;
    valid_r = 3'b000;
    granted_prev = 3'b000;
    last_op = 3'd0;
    accepts = 0;
    for (int i = 0; i < 3; i++) begin ops[i] = 3'd0; waits[i] = 0; end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      step();
      if (done_b) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_done_spurious cycle=%0d id=%0d want no done", cyc, done_id_b);
        end else begin
          want = exp_q.pop_front();
          if (done_id_b !== want) begin failures++; $display("FAIL rand_done_id cycle=%0d got=%0d want=%0d", cyc, done_id_b, want); end
        end
      end
      if (str_b != 7'h7F) begin
        checks++;
        if (str_b !== exp_mask(last_op)) begin failures++; $display("FAIL rand_strobe cycle=%0d got=%h want=%h", cyc, str_b, exp_mask(last_op)); end
      end
      for (int i = 0; i < 3; i++) begin
        if (granted_prev[i]) begin
          valid_r[i] = 1'b0;
        end else if (valid_r[i]) begin
          if ($urandom_range(0, 49) == 0) begin valid_r[i] = 1'b0; waits[i] = 0; end
        end else if ($urandom_range(0, 2) == 0) begin
          valid_r[i] = 1'b1;
          ops[i] = 3'($urandom_range(0, 7));
          waits[i] = 0;
        end
      end
      valid_b = valid_r;
      op_b = {ops[2], ops[1], ops[0]};
      #1;
      checks++;
      if ((ready_b & ~valid_r) != 3'b000 || !$onehot0(ready_b)) begin
        failures++; $display("FAIL rand_ready cycle=%0d ready=%b valid=%b", cyc, ready_b, valid_r);
      end
      granted_prev = ready_b;
      if (ready_b != 3'b000) begin
        accepts++;
        for (int i = 0; i < 3; i++) begin
          if (ready_b[i]) begin
            exp_q.push_back(3'(i));
            last_op = ops[i];
            waits[i] = 0;
          end else if (valid_r[i]) begin
            waits[i]++;
          end
        end
        checks++;
        if (waits[0] > 3 || waits[1] > 3 || waits[2] > 3) begin
          failures++; $display("FAIL rand_starve cycle=%0d waits=%0d,%0d,%0d want <=3", cyc, waits[0], waits[1], waits[2]);
        end
      end
    end
    valid_b = 3'b000;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done_b) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_drain_spurious id=%0d want no done", done_id_b);
        end else begin
          want = exp_q.pop_front();
          if (done_id_b !== want) begin failures++; $display("FAIL rand_drain_id got=%0d want=%0d", done_id_b, want); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_missing_done pending=%0d want=0", exp_q.size()); end
    checks++; if (accepts < 200) begin failures++; $display("FAIL rand_accepts got=%0d want>=200", accepts); end
  endtask

  initial begin
    test_reset();
    test_ld_hi();
    test_nop();
    test_round_robin();
    test_long_strobe();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
